// File: rtl/fpu_mul_issue_pkg.sv
// Shared FPU types for the FP16 multiplier issue controller.
// Holds the operand/condition-code types, the qNaN constant and the controller state enum.
package fpu_mul_issue_pkg;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] frac;
  } fp16_t;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } condCode_t;

  localparam fp16_t FP16_QNAN = 16'h7E00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_START,
    ST_BUSY,
    ST_RESULT
  } fpuMulIssueState_t;

  function automatic logic fp16_is_zero(fp16_t x);
    return (x.exp == 5'd0) && (x.frac == 10'd0);
  endfunction

endpackage

// File: rtl/fpu_mul_issue_watchdog.sv
// Watchdog for the issue controller: 8-bit up-counter that flags the last
// permitted BUSY cycle (count == TIMEOUT-1).
module fpuMulWatchdog #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/fpu_mul_issue.sv
// Issue/retire controller in front of the sequential FP16 multiplier.
// Optional zero-operand bypass enabled by defining FPU_MUL_ZERO_BYPASS_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for an operand pair, inReady=1
// ST_CLEAR  | one-cycle mulReset pulse to re-arm the multiplier's done latch
// ST_START  | one-cycle mulStart pulse, watchdog cleared
// ST_BUSY   | waiting for mulDone or watchdog expiry
// ST_RESULT | result presented until outReady
module fpu_mul_issue
  import fpu_mul_issue_pkg::*;
#(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      inValid,
  output logic      inReady,
  input  fp16_t     inA,
  input  fp16_t     inB,
  output fp16_t     mulIn1,
  output fp16_t     mulIn2,
  output logic      mulStart,
  output logic      mulReset,
  input  fp16_t     mulOut,
  input  condCode_t mulCond,
  input  logic      mulDone,
  output logic      outValid,
  input  logic      outReady,
  output fp16_t     outResult,
  output condCode_t outCond,
  output logic      outTimeout,
  output logic      busy
);

  fpuMulIssueState_t state_q;
  fp16_t             opA_q, opB_q, outResult_q;
  condCode_t         outCond_q;
  logic              mulStart_q, outValid_q, outTimeout_q;
  logic              accept_d, bypass_d, bypassSign_d, expired;

  assign inReady  = (state_q == ST_IDLE) | ((state_q == ST_RESULT) & outReady);
  assign accept_d = inValid & inReady;

`ifdef FPU_MUL_ZERO_BYPASS_EN
  assign bypass_d     = fp16_is_zero(inA) | fp16_is_zero(inB);
  assign bypassSign_d = inA.sign ^ inB.sign;
`else
  assign bypass_d     = 1'b0;
  assign bypassSign_d = 1'b0;
`endif

  fpuMulWatchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_q == ST_START),
    .enable  (state_q == ST_BUSY),
    .expired (expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      opA_q        <= '0;
      opB_q        <= '0;
      mulStart_q   <= 1'b0;
      outValid_q   <= 1'b0;
      outResult_q  <= '0;
      outCond_q    <= '0;
      outTimeout_q <= 1'b0;
    end else begin
      mulStart_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_RESULT: begin
          if (accept_d) begin
            opA_q <= inA;
            opB_q <= inB;
            if (bypass_d) begin
              state_q      <= ST_RESULT;
              outValid_q   <= 1'b1;
              outResult_q  <= {bypassSign_d, 15'b0};
              outCond_q    <= {~bypassSign_d, 1'b0, bypassSign_d, 1'b0};
              outTimeout_q <= 1'b0;
            end else begin
              state_q    <= ST_CLEAR;
              outValid_q <= 1'b0;
            end
          end else if ((state_q == ST_RESULT) && outReady) begin
            state_q    <= ST_IDLE;
            outValid_q <= 1'b0;
          end
        end
        ST_CLEAR: begin
          state_q    <= ST_START;
          mulStart_q <= 1'b1;
        end
        ST_START: state_q <= ST_BUSY;
        ST_BUSY: begin
          // a done seen on the expiry cycle still counts as a real result
          if (mulDone) begin
            state_q      <= ST_RESULT;
            outValid_q   <= 1'b1;
            outResult_q  <= mulOut;
            outCond_q    <= mulCond;
            outTimeout_q <= 1'b0;
          end else if (expired) begin
            state_q      <= ST_RESULT;
            outValid_q   <= 1'b1;
            outResult_q  <= FP16_QNAN;
            outCond_q    <= '0;
            outTimeout_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mulIn1     = opA_q;
  assign mulIn2     = opB_q;
  assign mulStart   = mulStart_q;
  assign mulReset   = ~reset | (state_q == ST_CLEAR);
  assign outValid   = outValid_q;
  assign outResult  = outResult_q;
  assign outCond    = outCond_q;
  assign outTimeout = outTimeout_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpu_mul_issue.sv
// Self-checking bench for fpu_mul_issue with a programmable-latency stub multiplier.
module tb_fpu_mul_issue;
  import fpu_mul_issue_pkg::*;

  localparam int TO = 32;

  logic      clock = 1'b0;
  logic      reset = 1'b0;
  logic      inValid = 1'b0, outReady = 1'b0;
  fp16_t     inA = '0, inB = '0;
  logic      inReady, mulStart, mulReset, outValid, outTimeout, busy;
  fp16_t     mulIn1, mulIn2, outResult;
  fp16_t     s_out;
  condCode_t s_cond, outCond;
  logic      s_done;
  logic [7:0] rem;
  int        stub_lat = 0;
  int        n_start = 0, n_mreset = 0;
  int        n_tests = 0, n_fail = 0;

  always #5 clock = ~clock;

  fpu_mul_issue #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady),
    .inA(inA), .inB(inB), .mulIn1(mulIn1), .mulIn2(mulIn2),
    .mulStart(mulStart), .mulReset(mulReset), .mulOut(s_out), .mulCond(s_cond),
    .mulDone(s_done), .outValid(outValid), .outReady(outReady),
    .outResult(outResult), .outCond(outCond), .outTimeout(outTimeout), .busy(busy)
  );

  // stub result: two real FP16 products, otherwise an operand hash
  function automatic logic [19:0] stub_fn(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3C00_4000: return {16'h4000, 4'b0000};
      32'hBE00_4000: return {16'hC200, 4'b0010};
      default:       return {a ^ {b[8:0], b[15:9]}, a[15:12] ^ b[3:0]};
    endcase
  endfunction

  // stub multiplier: done latches stub_lat edges after the start edge; lat 0 never completes
  always @(posedge clock or posedge mulReset) begin
    if (mulReset) begin
      rem    <= 8'd0;
      s_done <= 1'b0;
    end else if (mulStart) begin
      rem <= 8'(stub_lat);
    end else if (rem == 8'd1) begin
      rem             <= 8'd0;
      s_done          <= 1'b1;
      {s_out, s_cond} <= stub_fn(mulIn1, mulIn2);
    end else if (rem != 8'd0) begin
      rem <= rem - 8'd1;
    end
  end

  always @(negedge clock) begin
    if (mulStart) n_start <= n_start + 1;
    if (mulReset && reset) n_mreset <= n_mreset + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // reference behaviour from the controller's rules, counted in cycles after accept
  task automatic model(input logic [15:0] a, input logic [15:0] b, input int lat,
                       output logic [15:0] res, output logic [3:0] cond, output logic to,
                       output int cyc, output int pulses);
    logic [19:0] r;
`ifdef FPU_MUL_ZERO_BYPASS_EN
    if (a[14:0] == 15'd0 || b[14:0] == 15'd0) begin
      res = {a[15] ^ b[15], 15'b0};
      cond = {res == 16'd0, 1'b0, res[15], 1'b0};
      to = 1'b0; cyc = 1; pulses = 0;
      return;
    end
`endif
    pulses = 1;
    if (lat != 0 && lat <= TO - 1) begin
      r = stub_fn(a, b);
      res = r[19:4]; cond = r[3:0]; to = 1'b0; cyc = lat + 4;
    end else begin
      res = 16'h7E00; cond = 4'b0000; to = 1'b1; cyc = TO + 3;
    end
  endtask

  // entered and left at posedge+1 with the DUT idle
  task automatic run_txn(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input int lat, input int hold, input logic [15:0] eres,
                         input logic [3:0] econd, input logic eto, input int ecyc,
                         input int epulse);
    int cyc, s0, r0;
    logic stable;
    stub_lat = lat; inA = a; inB = b; inValid = 1'b1; outReady = (hold == 0);
    s0 = n_start; r0 = n_mreset;
    @(posedge clock); #1 inValid = 1'b0;
    cyc = 1;
    forever begin
      @(negedge clock);
      if (outValid || cyc >= 300) break;
      @(posedge clock);
      cyc++;
    end
    chk({nm, " latency"}, cyc, ecyc);
    chk({nm, " result"}, outResult, eres);
    chk({nm, " cond"}, outCond, econd);
    chk({nm, " timeout flag"}, outTimeout, eto);
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        if (!(outValid && outResult == eres && outCond == econd && !inReady)) stable = 1'b0;
        @(posedge clock); @(negedge clock);
      end
      chk({nm, " held stable"}, stable, 1);
      outReady = 1'b1;
    end
    @(posedge clock); #1;
    chk({nm, " mulStart pulses"}, n_start - s0, epulse);
    chk({nm, " mulReset pulses"}, n_mreset - r0, epulse);
    @(negedge clock);
    chk({nm, " idle after retire"}, {busy, outValid, inReady}, 3'b001);
    @(posedge clock); #1;
  endtask

  typedef struct {
    string       nm;
    logic [15:0] a, b;
    int          lat, hold;
    logic [15:0] res;
    logic [3:0]  cond;
    logic        to;
    int          cyc, pulses;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [15:0] a, b, eres;
    logic [3:0]  econd;
    logic        eto;
    int lat, hold, ecyc, ep, r;

    vecs.push_back('{"mul lat5",       16'h3C00, 16'h4000, 5,  0,  16'h4000, 4'b0000, 1'b0, 9,  1});
    vecs.push_back('{"neg held",       16'hBE00, 16'h4000, 3,  10, 16'hC200, 4'b0010, 1'b0, 7,  1});
    vecs.push_back('{"mul lat1",       16'h3C00, 16'h4000, 1,  0,  16'h4000, 4'b0000, 1'b0, 5,  1});
    vecs.push_back('{"no done",        16'h1234, 16'h5678, 0,  0,  16'h7E00, 4'b0000, 1'b1, 35, 1});
    vecs.push_back('{"done at expiry", 16'h3C00, 16'h4000, 31, 0,  16'h4000, 4'b0000, 1'b0, 35, 1});
    vecs.push_back('{"done too late",  16'h3C00, 16'h4000, 32, 0,  16'h7E00, 4'b0000, 1'b1, 35, 1});
`ifdef FPU_MUL_ZERO_BYPASS_EN
    vecs.push_back('{"zero operand",   16'h0000, 16'hC000, 5,  0,  16'h8000, 4'b0010, 1'b0, 1,  0});
`else
    vecs.push_back('{"zero operand",   16'h0000, 16'hC000, 5,  0,  16'h0060, 4'b0000, 1'b0, 9,  1});
`endif

    #12;
    chk("reset mulReset", mulReset, 1);
    chk("reset handshake", {inReady, outValid, busy, mulStart}, 4'b1000);
    chk("reset result regs", {outResult, outCond, outTimeout}, 21'd0);
    chk("reset operands", {mulIn1, mulIn2}, 32'd0);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;

    foreach (vecs[i])
      run_txn(vecs[i].nm, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].hold,
              vecs[i].res, vecs[i].cond, vecs[i].to, vecs[i].cyc, vecs[i].pulses);

    // back-to-back: second pair accepted in the retire cycle of the first
    stub_lat = 2; inA = 16'h3C00; inB = 16'h4000; inValid = 1'b1; outReady = 1'b1;
    @(posedge clock); #1 inA = 16'hBE00;
    r = 0;
    do begin @(negedge clock); r++; if (!outValid) @(posedge clock); end
    while (!outValid && r < 300);
    chk("b2b first result", outResult, 16'h4000);
    chk("b2b accept in retire", inReady, 1);
    @(posedge clock); @(negedge clock);
    chk("b2b clear follows", {mulReset, outValid}, 2'b10);
    chk("b2b second operand", mulIn1, 16'hBE00);
    inValid = 1'b0;
    r = 1;
    while (!outValid && r < 300) begin @(posedge clock); @(negedge clock); r++; end
    chk("b2b throughput", r, 2 + 4);
    chk("b2b second result", {outResult, outCond}, {16'hC200, 4'b0010});
    @(posedge clock); #1;

    // reset asserted while BUSY
    stub_lat = 20; inA = 16'h3C00; inB = 16'h4000; inValid = 1'b1;
    @(posedge clock); #1 inValid = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("busy before reset", {busy, mulReset}, 2'b10);
    reset = 1'b0; #1;
    chk("reset mid-op mulReset", mulReset, 1);
    chk("reset mid-op outputs", {busy, outValid, inReady}, 3'b001);
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    chk("after reset release", {busy, outValid, inReady, mulReset}, 4'b0010);
    @(posedge clock); #1;
    run_txn("post reset", 16'h3C00, 16'h4000, 4, 0, 16'h4000, 4'b0000, 1'b0, 8, 1);

    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      if (i % 6 == 0) a = (i % 12 == 0) ? 16'h8000 : 16'h0000;
      lat  = $urandom_range(0, 36);
      hold = $urandom_range(0, 3);
      model(a, b, lat, eres, econd, eto, ecyc, ep);
      run_txn($sformatf("rand%0d", i), a, b, lat, hold, eres, econd, eto, ecyc, ep);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_mul_issue.md
# fpu_mul_issue

Issue/retire controller that sits directly in front of the sequential FP16 multiplier. It accepts operand pairs over a valid/ready handshake and holds them stable on the multiplier inputs. It re-arms the multiplier, which latches `done` until reset, by pulsing its reset, then pulses `start`. It captures the result and condition codes when `done` rises and presents them downstream over a second valid/ready handshake. A watchdog flags a multiplier that never completes.

## Interface
- `TIMEOUT`, default 32: maximum cycles spent in BUSY before the watchdog fires; legal range 2..255.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `inValid`  in  1  operand pair valid.
- `inReady`  out  1  block can accept an operand pair.
- `inA`, `inB`  in  16 (`fp16_t`)  operands.
- `mulIn1`, `mulIn2`  out  16 (`fp16_t`)  registered operands to the multiplier.
- `mulStart`  out  1  one-cycle start pulse to the multiplier.
- `mulReset`  out  1  active-high reset to the multiplier.
- `mulOut`  in  16 (`fp16_t`)  multiplier result.
- `mulCond`  in  4 (`condCode_t`)  multiplier {Z,C,N,V}.
- `mulDone`  in  1  multiplier done level.
- `outValid`  out  1  result valid.
- `outReady`  in  1  downstream accepts result.
- `outResult`  out  16 (`fp16_t`)  registered result.
- `outCond`  out  4 (`condCode_t`)  registered condition codes.
- `outTimeout`  out  1  result was produced by the watchdog; data invalid.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States are IDLE, CLEAR, START, BUSY, RESULT.
- **IDLE**: `inReady`=1. On `inValid`, latch `inA`/`inB` into the operand registers and go to CLEAR.
- **CLEAR**: `mulReset`=1 for exactly one cycle, then go to START.
- **START**: `mulStart`=1 for exactly one cycle. Clear the watchdog counter, then go to BUSY.
- **BUSY**: the counter increments every cycle.
  - On `mulDone`=1, capture `mulOut` and `mulCond`, set `outTimeout`=0, and go to RESULT.
  - Otherwise, when the counter reaches `TIMEOUT`-1, capture `outResult`=0x7E00 (qNaN) and `outCond`=4'b0000, set `outTimeout`=1, and go to RESULT.
  - If `mulDone` is seen on the same cycle the counter expires, `mulDone` wins.
- **RESULT**: `outValid`=1, with `outResult`, `outCond` and `outTimeout` held stable until `outReady`.
  - `inReady` = `outReady` in this state, so a new pair can be accepted in the retire cycle.
  - On `outReady` with `inValid`: latch the new pair and go to CLEAR.
  - On `outReady` without `inValid`: go to IDLE.
- `mulIn1`/`mulIn2` change only on an accept and stay stable through CLEAR, START and BUSY.
- `mulReset` = (~`reset`) | (state == CLEAR). It is combinational, so the multiplier resets asynchronously with this block.
- `mulDone` is ignored outside BUSY.

## Timing
- Reset values:
  - state IDLE.
  - `inReady`=1.
  - `mulStart`=0.
  - `mulReset`=1 while held in reset.
  - `outValid`=0, `outResult`=0, `outCond`=0, `outTimeout`=0, `busy`=0.
  - operand registers and counter = 0.
- Accept at cycle 0. CLEAR is cycle 1, START is cycle 2, and BUSY starts at cycle 3.
- `mulDone` sampled high in cycle k gives `outValid`=1 in cycle k+1.
- Issue overhead is 3 cycles plus the multiplier latency plus 1 cycle to present.
- Back-to-back throughput: one result per (multiplier latency + 4) cycles.
- Reset asserted mid-operation: return to IDLE immediately; the in-flight operation and any pending result are discarded.

## Configuration
- Macro: `FPU_MUL_ZERO_BYPASS_EN`.
- **Defined**: on accept, if either operand has exp==0 and frac==0, skip CLEAR, START and BUSY. The next cycle is RESULT with:
  - `outResult` = {inA.sign ^ inB.sign, 15'b0}.
  - `outCond` = {Z=(outResult==0), C=0, N=sign, V=0}.
  - `outTimeout`=0.
  - No `mulStart` or `mulReset` pulse.
- **Undefined**: zero operands take the normal path.

## Structure
- Shared FPU package holds:
  - `fp16_t`, `condCode_t`.
  - constant `FP16_QNAN` = 16'h7E00.
  - state enum `fpuMulIssueState_t`.
- One sub-module, `fpuMulWatchdog`: 8-bit counter with `clear`, `enable` and `expired` (counter == `TIMEOUT`-1).

## Test plan
- 0x3C00 × 0x4000, `outReady`=1, with a stub multiplier of latency 5 → `outResult`=0x4000, `outCond`=0000, `outValid` at cycle 9 after accept; exactly one `mulReset` pulse and one `mulStart` pulse.
- 0xBE00 × 0x4000 with `outReady` held low for 10 cycles → `outValid` stays high with 0xC200, N=1 stable throughout; `inReady`=0 while held.
- Back-to-back: second pair presented during RESULT with `outReady`=1 → second accepted that cycle; CLEAR follows the next cycle; both results retire in order.
- Stub never asserts `mulDone`, `TIMEOUT`=32 → RESULT reached 32 cycles after BUSY entry with 0x7E00 and `outTimeout`=1.
- With the macro defined: 0x0000 × 0xC000 → `outResult`=0x8000, Z=0, N=1, `outValid` 1 cycle after accept, no `mulStart`. Without the macro: normal latency.
- Assert `reset` in BUSY → `mulReset`=1 immediately; after release, state IDLE, `outValid`=0, `inReady`=1.
